// File: rtl/rom_loader_pkg.sv
// Shared definitions for the instruction-store loader: word geometry and FSM encodings.
package rom_loader_pkg;

  localparam int unsigned INST_WIDTH     = 28;
  localparam int unsigned BYTES_PER_INST = 4;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CNT_HI = 3'd1;
  localparam logic [2:0] S_CNT_LO = 3'd2;
  localparam logic [2:0] S_BYTES  = 3'd3;
  localparam logic [2:0] S_WRITE  = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;
  localparam logic [2:0] S_ERROR  = 3'd6;

  // The leading byte of each instruction carries only the 4 MSBs of the word.
  function automatic logic bad_lead_nibble(input logic [7:0] b);
    return b[7:4] != 4'h0;
  endfunction

endpackage

// File: rtl/rom_loader_assembler.sv
// Big-endian 4-byte instruction assembler with byte counter and lead-nibble check.
module rom_loader_assembler
  import rom_loader_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  shift,
  input  logic [7:0]            din,
  output logic [INST_WIDTH-1:0] word_next,
  output logic                  last,
  output logic                  nibble_err
);

  logic [23:0] sr;
  logic [1:0]  cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr  <= '0;
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (shift) begin
      sr  <= {sr[15:0], din};
      cnt <= cnt + 2'd1;
    end
  end

  // Word as it will look once din is shifted in, so the write can be registered on the 4th byte.
  assign word_next  = {sr[19:0], din};
  assign last       = (cnt == 2'(BYTES_PER_INST - 1));
  assign nibble_err = (cnt == 2'd0) && bad_lead_nibble(din);

endmodule

// File: rtl/rom_loader.sv
// Loads a counted byte stream of 28-bit instructions into the instruction RAM, holding the CPU in reset meanwhile.
module rom_loader
  import rom_loader_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 16,
  parameter int unsigned           INST_WIDTH = rom_loader_pkg::INST_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  iStart,
  input  logic [7:0]            iByte,
  input  logic                  iByteValid,
  output logic                  oByteReady,
  output logic                  oWrEnable,
  output logic [ADDR_WIDTH-1:0] oWrAddress,
  output logic [INST_WIDTH-1:0] oWrData,
  output logic                  oCpuHold,
  output logic                  oDone,
  output logic                  oError
);

  logic [2:0]            state;
  logic [15:0]           n;
  logic [15:0]           index;
  logic                  xfer;
  logic [INST_WIDTH-1:0] word_next;
  logic                  last;
  logic                  nibble_err;

  assign oByteReady = (state == S_CNT_HI) || (state == S_CNT_LO) || (state == S_BYTES);
  assign xfer       = iByteValid && oByteReady;
  assign oWrEnable  = (state == S_WRITE);
  assign oCpuHold   = (state != S_DONE);
  assign oDone      = (state == S_DONE);
  assign oError     = (state == S_ERROR);

  rom_loader_assembler u_asm (
    .clk        (Clock),
    .rst_n      (Reset),
    .clear      (state != S_BYTES),
    .shift      (xfer && (state == S_BYTES)),
    .din        (iByte),
    .word_next  (word_next),
    .last       (last),
    .nibble_err (nibble_err)
  );

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state      <= S_IDLE;
      n          <= '0;
      index      <= '0;
      oWrAddress <= BASE_ADDR;
      oWrData    <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (iStart) begin
            state <= S_CNT_HI;
            index <= '0;
          end
        end
        S_CNT_HI: begin
          if (xfer) begin
            n[15:8] <= iByte;
            state   <= S_CNT_LO;
          end
        end
        S_CNT_LO: begin
          if (xfer) begin
            n[7:0] <= iByte;
            state  <= ({n[15:8], iByte} == 16'd0) ? S_DONE : S_BYTES;
          end
        end
        S_BYTES: begin
          if (xfer) begin
            if (nibble_err) begin
              state <= S_ERROR;
            end else if (last) begin
              // Address and data are captured here so they are stable for the whole WRITE cycle.
              state      <= S_WRITE;
              oWrAddress <= BASE_ADDR + ADDR_WIDTH'(index);
              oWrData    <= word_next;
            end
          end
        end
        S_WRITE: begin
          index <= index + 16'd1;
          state <= ((index + 16'd1) == n) ? S_DONE : S_BYTES;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
